fp_addsub_mc: RTL and testbench

FP_ADDSUB_MC -- requirements
Module: fp_addsub_mc

---
 rtl/fp_pkg.sv | 28 ++
 rtl/fp_lzc.sv | 20 ++
 rtl/fp_addsub_mc.sv | 265 ++++++++++++++++++++++++++
 tb/tb_fp_addsub_mc.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the multi-cycle floating-point adder/subtractor.
//   state_t       : controller states, one cycle each
//   FP_EXP_W/MAN_W: default IEEE single-precision field widths
//   FP_EXP_ONES   : all-ones exponent for the default width (inf/NaN marker)
//   FP_BIAS       : exponent bias for the default width
//   exp_all_ones(): all-ones exponent value for any exponent width
package fp_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  localparam int FP_EXP_ONES = (1 << FP_EXP_W) - 1;
  localparam int FP_BIAS     = (1 << (FP_EXP_W - 1)) - 1;

  function automatic int exp_all_ones(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: leading-zero counter.
//   din : vector to scan, MSB first
//   cnt : number of zeros above the most significant set bit (WIDTH when din==0)
module fp_lzc #(
  parameter int WIDTH = 27,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] cnt
);

  // Scanning upward lets the highest set bit win as the last assignment.
  always_comb begin
    cnt = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) cnt = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_mc.sv
// fp_addsub_mc: multi-cycle IEEE-style add/subtract, denormals flushed to zero.
// Pipeline of states IDLE->ALIGN->ADD->NORM->ROUND->DONE, one cycle each.
// Optional build macro: FP_ADDSUB_RNE_EN enables round-to-nearest-even in ROUND;
// without it ROUND truncates (latency unchanged).
// Ports:
//   clk, n_rst        : clock (rising edge), async active-low reset
//   start, mode       : request (sampled in IDLE only), 0 = op1+op2, 1 = op1-op2
//   op1, op2          : operands {sign, exp, man}
//   busy, done        : busy outside IDLE; done is a one-cycle pulse in DONE
//   result            : sum/difference, held until the next done
//   overflow/underflow/zero : status, held with result
//   dbg_state         : current controller state (state_t encoding)
//
// Handshake: a request is accepted on a rising edge where start=1 and busy=0;
// operands and mode are captured on that edge. Requests while busy=1 are
// dropped. done rises exactly 5 cycles after the accepting cycle and result
// and flags are valid from that cycle until the next done.
module fp_addsub_mc
  import fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
  input  logic                   mode,
  input  logic [EXP_W+MAN_W:0]   op1,
  input  logic [EXP_W+MAN_W:0]   op2,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   zero,
  output logic [2:0]             dbg_state
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int M   = MAN_W + 1;          // mantissa with hidden bit
  localparam int XW  = M + 3;              // plus guard/round/sticky
  localparam int SW  = XW + 1;             // plus carry
  localparam int EW  = EXP_W + 2;          // signed exponent headroom
  localparam int LZW = $clog2(XW + 1);

  localparam logic [EXP_W-1:0]    EXP_ONES   = '1;
  localparam logic signed [EW-1:0] EXP_ONES_S = EW'(exp_all_ones(EXP_W));

  // ---------------- controller ----------------
  state_t state_q, state_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      S_IDLE:  begin
        busy = 1'b0;
        if (start) state_d = S_ALIGN;
      end
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dbg_state = state_q;

  // ---------------- datapath registers ----------------
  logic [W-1:0]           op_a_q, op_b_q;
  logic                   sign_q, eff_sub_q, special_q;
  logic [W-1:0]           special_val_q;
  logic [EXP_W-1:0]       exp_q;
  logic [XW-1:0]          a_al_q, b_al_q;
  logic [SW-1:0]          sum_q;
  logic [XW-1:0]          norm_q;
  logic signed [EW-1:0]   nexp_q;
  logic                   zero_q;
  logic [W-1:0]           result_q;
  logic                   ovf_q, unf_q, zero_flag_q;

  // ---------------- ALIGN ----------------
  logic [EXP_W-1:0]       a_exp, b_exp, big_exp, small_exp, diff;
  logic [MAN_W-1:0]       a_man, b_man;
  logic                   a_zero, b_zero, swap;
  logic [XW-1:0]          a_full, b_full, big_full, small_full, small_al;
  logic [2*XW-1:0]        wide;
  logic                   align_special;
  logic [W-1:0]           align_special_val;

  always_comb begin
    a_exp  = op_a_q[W-2:MAN_W];
    b_exp  = op_b_q[W-2:MAN_W];
    a_zero = (a_exp == '0);
    b_zero = (b_exp == '0);
    // Exponent 0 flushes the whole mantissa, hidden bit included.
    a_man  = a_zero ? '0 : op_a_q[MAN_W-1:0];
    b_man  = b_zero ? '0 : op_b_q[MAN_W-1:0];
    a_full = {~a_zero, a_man, 3'b000};
    b_full = {~b_zero, b_man, 3'b000};
    swap   = {b_exp, b_man} > {a_exp, a_man};

    big_exp    = swap ? b_exp  : a_exp;
    small_exp  = swap ? a_exp  : b_exp;
    big_full   = swap ? b_full : a_full;
    small_full = swap ? a_full : b_full;
    diff       = big_exp - small_exp;

    // Shift through a double-width window so everything shifted out of the
    // low half collapses into the sticky bit.
    wide = {small_full, {XW{1'b0}}} >> diff;
    if (int'(diff) >= MAN_W + 3)
      small_al = {{(XW-1){1'b0}}, |small_full};
    else
      small_al = wide[2*XW-1:XW] | {{(XW-1){1'b0}}, |wide[XW-1:0]};

    align_special     = 1'b0;
    align_special_val = op_a_q;
    if (a_exp == EXP_ONES) begin
      align_special     = 1'b1;
      align_special_val = op_a_q;
    end else if (b_exp == EXP_ONES) begin
      align_special     = 1'b1;
      align_special_val = op_b_q;
    end
  end

  // ---------------- NORM ----------------
  logic [LZW-1:0]         lzc;
  logic [XW-1:0]          norm_d;
  logic signed [EW-1:0]   nexp_d;

  fp_lzc #(.WIDTH(XW), .CNT_W(LZW)) u_lzc (
    .din (sum_q[XW-1:0]),
    .cnt (lzc)
  );

  always_comb begin
    if (sum_q[SW-1]) begin
      // Carry out: one right shift, the dropped bit folds into sticky.
      norm_d = {sum_q[SW-1:2], sum_q[1] | sum_q[0]};
      nexp_d = $signed({2'b00, exp_q}) + EW'(1);
    end else begin
      norm_d = sum_q[XW-1:0] << lzc;
      nexp_d = $signed({2'b00, exp_q}) - $signed(EW'(lzc));
    end
  end

  // ---------------- ROUND ----------------
  logic [M-1:0]           mant;
  logic                   round_up;
  logic [M:0]             mant_r;
  logic [MAN_W-1:0]       fman;
  logic signed [EW-1:0]   fexp;
  logic [W-1:0]           res_d;
  logic                   ovf_d, unf_d, zero_d;

`ifdef FP_ADDSUB_RNE_EN
  // Round up when above half, or exactly half with an odd LSB.
  assign round_up = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
`else
  logic unused_grs;
  assign unused_grs = ^norm_q[2:0];
  assign round_up   = 1'b0;
`endif

  always_comb begin
    mant   = norm_q[XW-1:3];
    mant_r = {1'b0, mant} + (M+1)'(round_up);
    // Mantissa carry from rounding means 10.000..., renormalise by one.
    fman   = mant_r[M] ? mant_r[M-1:1] : mant_r[MAN_W-1:0];
    fexp   = nexp_q + EW'(mant_r[M]);

    res_d = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    zero_d = 1'b0;
    if (special_q) begin
      res_d = special_val_q;
    end else if (zero_q) begin
      zero_d = 1'b1;
    end else if (nexp_q <= 0) begin
      res_d  = {sign_q, {(W-1){1'b0}}};
      unf_d  = 1'b1;
      zero_d = 1'b1;
    end else if (fexp >= EXP_ONES_S) begin
      res_d = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
    end else begin
      res_d = {sign_q, fexp[EXP_W-1:0], fman};
    end
  end

  // ---------------- stage registers ----------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      op_a_q        <= '0;
      op_b_q        <= '0;
      sign_q        <= 1'b0;
      eff_sub_q     <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      exp_q         <= '0;
      a_al_q        <= '0;
      b_al_q        <= '0;
      sum_q         <= '0;
      norm_q        <= '0;
      nexp_q        <= '0;
      zero_q        <= 1'b0;
      result_q      <= '0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
      zero_flag_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          op_a_q <= op1;
          op_b_q <= {op2[W-1] ^ mode, op2[W-2:0]};
        end
        S_ALIGN: begin
          sign_q        <= swap ? op_b_q[W-1] : op_a_q[W-1];
          eff_sub_q     <= op_a_q[W-1] ^ op_b_q[W-1];
          exp_q         <= big_exp;
          a_al_q        <= big_full;
          b_al_q        <= small_al;
          special_q     <= align_special;
          special_val_q <= align_special_val;
        end
        S_ADD: begin
          sum_q <= eff_sub_q ? ({1'b0, a_al_q} - {1'b0, b_al_q})
                             : ({1'b0, a_al_q} + {1'b0, b_al_q});
        end
        S_NORM: begin
          norm_q <= norm_d;
          nexp_q <= nexp_d;
          zero_q <= (sum_q == '0);
        end
        S_ROUND: begin
          result_q    <= res_d;
          ovf_q       <= ovf_d;
          unf_q       <= unf_d;
          zero_flag_q <= zero_d;
        end
        default: ;
      endcase
    end
  end

  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign zero      = zero_flag_q;

endmodule

// File: tb/tb_fp_addsub_mc.sv
// tb_fp_addsub_mc: directed self-checking bench for fp_addsub_mc (single precision).
module tb_fp_addsub_mc;

  localparam int W = 32;

  logic          clk;
  logic          n_rst;
  logic          start;
  logic          mode;
  logic [W-1:0]  op1, op2;
  logic          busy, done;
  logic [W-1:0]  result;
  logic          overflow, underflow, zero;
  logic [2:0]    dbg_state;

  logic [W+2:0]  exp_q[$];   // {overflow, underflow, zero, result}
  int            n_checks = 0;
  int            n_fail   = 0;
  int            done_cnt = 0;

  fp_addsub_mc #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .mode      (mode),
    .op1       (op1),
    .op2       (op2),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .zero      (zero),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv)
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (n_rst && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(result), 64'hDEAD_BEEF_DEAD_BEEF);
      end else begin
        logic [W+2:0] e;
        e = exp_q.pop_front();
        check("result_flags", 64'({overflow, underflow, zero, result}), 64'(e));
      end
    end
  end

  // ---------------- driver ----------------
  // poke_cyc: cycle after acceptance at which a second start is attempted (0 = none)
  // rst_cyc : cycle after acceptance at which reset is asserted (0 = none)
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        input logic [W-1:0] res, input logic [2:0] flags,
                        input int poke_cyc, input int rst_cyc);
    int cyc;
    bit seen;
    int done_before;
    if (rst_cyc == 0) exp_q.push_back({flags, res});
    @(negedge clk);
    op1 = a; op2 = b; mode = m; start = 1'b1;
    @(posedge clk);
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == poke_cyc) begin
        start = 1'b1;
        op1 = 32'h4120_0000;
        op2 = 32'hC2C8_0000;
        mode = ~m;
      end
      if (cyc == rst_cyc) begin
        done_before = done_cnt;
        n_rst = 1'b0;
        #1;
        check("abort_state", 64'(dbg_state), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_out", 64'({done, overflow, underflow, zero, result}), 64'd0);
        repeat (6) @(negedge clk);
        check("abort_no_done", 64'(done_cnt), 64'(done_before));
        n_rst = 1'b1;
        return;
      end
      if (done) seen = 1;
    end
    check("latency", 64'(cyc), 64'd5);
    @(negedge clk);
    start = 1'b0;
    check("back_idle", 64'({busy, done}), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_rst = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    op1   = '0;
    op2   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'({overflow, underflow, zero}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // 1.25 + 1.5 = 2.75
    run_op(32'h3FA0_0000, 32'h3FC0_0000, 1'b0, 32'h4030_0000, 3'b000, 0, 0);
    // 1.5 - 1.25 = 0.25, left-normalised by 2
    run_op(32'h3FC0_0000, 32'h3FA0_0000, 1'b1, 32'h3E80_0000, 3'b000, 0, 0);
    // 1.0 - 1.0 = +0
    run_op(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 3'b001, 0, 0);
    // max + max overflows to +inf
    run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3'b100, 0, 0);
    // guard=1, round=1 below the LSB
`ifdef FP_ADDSUB_RNE_EN
    run_op(32'h3F80_0000, 32'h33C0_0000, 1'b0, 32'h3F80_0001, 3'b000, 0, 0);
`else
    run_op(32'h3F80_0000, 32'h33C0_0000, 1'b0, 32'h3F80_0000, 3'b000, 0, 0);
`endif
    // exact half, even LSB stays
    run_op(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 3'b000, 0, 0);
    // 1.0 - tiny: sticky only, borrow gives all-ones mantissa below 1.0
`ifdef FP_ADDSUB_RNE_EN
    run_op(32'h3F80_0000, 32'h0080_0000, 1'b1, 32'h3F80_0000, 3'b000, 0, 0);
`else
    run_op(32'h3F80_0000, 32'h0080_0000, 1'b1, 32'h3F7F_FFFF, 3'b000, 0, 0);
`endif
    // 1.0 - (-1.0) = 2.0
    run_op(32'h3F80_0000, 32'hBF80_0000, 1'b1, 32'h4000_0000, 3'b000, 0, 0);
    // -0 + -0 = +0
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 3'b001, 0, 0);
    // min normal - next normal underflows, sign of the larger (negated) op2
    run_op(32'h0080_0000, 32'h0080_0001, 1'b1, 32'h8000_0000, 3'b011, 0, 0);
    // op1 infinity passes through
    run_op(32'h7F80_0000, 32'h3F80_0000, 1'b1, 32'h7F80_0000, 3'b000, 0, 0);
    // op2 infinity passes through after the subtraction sign flip
    run_op(32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 3'b000, 0, 0);
    // second start while busy is ignored
    run_op(32'h3FA0_0000, 32'h3FC0_0000, 1'b0, 32'h4030_0000, 3'b000, 2, 0);
    // reset asserted while in NORM aborts the operation
    run_op(32'h3FC0_0000, 32'h3FA0_0000, 1'b1, 32'h0, 3'b000, 0, 3);
    @(negedge clk);
    // first request after the abort completes normally
    run_op(32'h3FC0_0000, 32'h3FA0_0000, 1'b1, 32'h3E80_0000, 3'b000, 0, 0);

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL timeout observed=stuck expected=finish");
    $fatal(1, "timeout");
  end

endmodule
